// File: rtl/rgmii_pkg.sv
// Shared encodings for the RGMII receive path: speed codes, preamble/SFD values
// and the nibble-assembler state type.
package rgmii_pkg;

    localparam logic [1:0] SPEED_10   = 2'b00;
    localparam logic [1:0] SPEED_100  = 2'b01;
    localparam logic [1:0] SPEED_1000 = 2'b10;

    localparam logic [3:0] PRE_NIB  = 4'h5;
    localparam logic [3:0] SFD_NIB  = 4'hD;
    localparam logic [7:0] SFD_BYTE = 8'hD5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HUNT = 2'd1,
        ST_LOW  = 2'd2,
        ST_HIGH = 2'd3
    } rx_state_e;

    // Any code with bit 1 set selects gigabit byte mode.
    function automatic logic is_gig(input logic [1:0] spd);
        return !(spd == SPEED_10 || spd == SPEED_100);
    endfunction

endpackage

// File: rtl/rgmii_inband_status.sv
// RGMII in-band link status decoder: the idle nibble is accepted only after it
// repeats on two consecutive inter-frame cycles.
module rgmii_inband_status
    import rgmii_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] rxd,
    input  logic       rx_dv,
    input  logic       rx_er,
    output logic       link_up,
    output logic [1:0] link_speed,
    output logic       link_duplex
);

    logic [3:0] cand_q, cand_d;
    logic       match_q, match_d;
    logic [3:0] stat_q, stat_d;

    always_comb begin
        cand_d  = cand_q;
        match_d = 1'b0;
        stat_d  = stat_q;
        // Frame or error cycles break the run of matching idle nibbles.
        if (!rx_dv && !rx_er) begin
            if (match_q && (cand_q == rxd)) begin
                stat_d = rxd;
            end
            cand_d  = rxd;
            match_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cand_q  <= 4'h0;
            match_q <= 1'b0;
            stat_q  <= 4'h0;
        end else begin
            cand_q  <= cand_d;
            match_q <= match_d;
            stat_q  <= stat_d;
        end
    end

    assign link_up     = stat_q[0];
    assign link_speed  = stat_q[2:1];
    assign link_duplex = stat_q[3];

endmodule

// File: rtl/gmii_rx_nibble_assembler.sv
// Receive-side nibble-to-byte assembler: gigabit bytes pass through, while at
// 10M/100M nibble pairs are aligned on the SFD and emitted with a clock enable.
module gmii_rx_nibble_assembler
    import rgmii_pkg::*;
#(
    parameter int unsigned ENABLE_INBAND_STATUS = 1,
    parameter int unsigned SFD_ALIGN            = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] speed,
    input  logic [7:0] in_rxd,
    input  logic       in_rx_dv,
    input  logic       in_rx_er,
    output logic [7:0] out_rxd,
    output logic       out_rx_dv,
    output logic       out_rx_er,
    output logic       out_clk_en,
    output logic       align_err,
    output logic       link_up,
    output logic [1:0] link_speed,
    output logic       link_duplex
);

    rx_state_e  state_q, state_d;
    logic [1:0] lspd_q, lspd_d;
    logic [1:0] eff_spd;
    logic [3:0] nib_q, nib_d;
    logic       nib_er_q, nib_er_d;
    logic [3:0] prev_q, prev_d;
    logic [7:0] rxd_q, rxd_d;
    logic       dv_q, dv_d;
    logic       er_q, er_d;
    logic       clk_en_q, clk_en_d;
    logic       align_err_q, align_err_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            lspd_q      <= SPEED_10;
            nib_q       <= 4'h0;
            nib_er_q    <= 1'b0;
            prev_q      <= 4'h0;
            rxd_q       <= 8'h00;
            dv_q        <= 1'b0;
            er_q        <= 1'b0;
            clk_en_q    <= 1'b0;
            align_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lspd_q      <= lspd_d;
            nib_q       <= nib_d;
            nib_er_q    <= nib_er_d;
            prev_q      <= prev_d;
            rxd_q       <= rxd_d;
            dv_q        <= dv_d;
            er_q        <= er_d;
            clk_en_q    <= clk_en_d;
            align_err_q <= align_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        lspd_d      = lspd_q;
        nib_d       = nib_q;
        nib_er_d    = nib_er_q;
        prev_d      = in_rxd[3:0];
        rxd_d       = rxd_q;
        dv_d        = dv_q;
        er_d        = er_q;
        clk_en_d    = 1'b0;
        align_err_d = 1'b0;

        // Live speed applies while idle so a new frame starts at the current
        // rate; once a frame is underway the latched speed is used.
        eff_spd = (state_q == ST_IDLE) ? speed : lspd_q;
        if (state_q == ST_IDLE) begin
            lspd_d = speed;
        end

        if (is_gig(eff_spd)) begin
            rxd_d    = in_rxd;
            dv_d     = in_rx_dv;
            er_d     = in_rx_er;
            clk_en_d = 1'b1;
            state_d  = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    dv_d     = 1'b0;
                    er_d     = 1'b0;
                    clk_en_d = ~clk_en_q;
                    if (in_rx_dv) begin
                        if (SFD_ALIGN != 0) begin
                            state_d = ST_HUNT;
                        end else begin
                            nib_d    = in_rxd[3:0];
                            nib_er_d = in_rx_er;
                            state_d  = ST_HIGH;
                        end
                    end
                end
                ST_HUNT: begin
                    if (!in_rx_dv) begin
                        state_d = ST_IDLE;
                    end else if ((prev_q == PRE_NIB) && (in_rxd[3:0] == SFD_NIB)) begin
                        rxd_d    = SFD_BYTE;
                        dv_d     = 1'b1;
                        er_d     = in_rx_er;
                        clk_en_d = 1'b1;
                        state_d  = ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (!in_rx_dv) begin
                        dv_d     = 1'b0;
                        er_d     = 1'b0;
                        clk_en_d = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        nib_d    = in_rxd[3:0];
                        nib_er_d = in_rx_er;
                        state_d  = ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (!in_rx_dv) begin
                        // Odd nibble count: drop the orphan nibble and flag it.
                        dv_d        = 1'b0;
                        er_d        = 1'b0;
                        clk_en_d    = 1'b1;
                        align_err_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        rxd_d    = {in_rxd[3:0], nib_q};
                        er_d     = nib_er_q | in_rx_er;
                        dv_d     = 1'b1;
                        clk_en_d = 1'b1;
                        state_d  = ST_LOW;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign out_rxd    = rxd_q;
    assign out_rx_dv  = dv_q;
    assign out_rx_er  = er_q;
    assign out_clk_en = clk_en_q;
    assign align_err  = align_err_q;

    generate
        if (ENABLE_INBAND_STATUS != 0) begin : g_status
            rgmii_inband_status u_status (
                .clk         (clk),
                .rst_n       (rst_n),
                .rxd         (in_rxd[3:0]),
                .rx_dv       (in_rx_dv),
                .rx_er       (in_rx_er),
                .link_up     (link_up),
                .link_speed  (link_speed),
                .link_duplex (link_duplex)
            );
        end else begin : g_no_status
            assign link_up     = 1'b0;
            assign link_speed  = 2'b00;
            assign link_duplex = 1'b0;
        end
    endgenerate

endmodule
